// File: rtl/counter_uni_mod_if.sv
// Control and status bundle for counter_uni_mod; the master drives mode/limit/step, the slave returns count and flags.
interface counter_uni_mod_if #(
  parameter int WIDTH = 8,
  parameter int STEPW = 4
);
  logic             en;
  logic             load_n;
  logic [WIDTH-1:0] preld_val;
  logic             updown;
  logic             wrapstop;
  logic [WIDTH-1:0] limit;
  logic [STEPW-1:0] step;
  logic             clr_flags;
  logic [WIDTH-1:0] dcout;
  logic             overflow;
  logic             underflow;
  logic             tc;
  logic             ovf_sticky;

  modport master (
    output en, load_n, preld_val, updown, wrapstop, limit, step, clr_flags,
    input  dcout, overflow, underflow, tc, ovf_sticky
  );

  modport slave (
    input  en, load_n, preld_val, updown, wrapstop, limit, step, clr_flags,
    output dcout, overflow, underflow, tc, ovf_sticky
  );
endinterface

// File: rtl/counter_uni_mod.sv
// Up/down modulo-(limit+1) counter with step, preload, wrap or stop-to-HALT, and sticky boundary flag.
// One cycle from sampled inputs to dcout/pulses; tc is combinational; no backpressure, en gates counting.
module counter_uni_mod #(
  parameter int               WIDTH     = 8,
  parameter int               STEPW     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk_i,
  input logic               areset_n_i,
  counter_uni_mod_if.slave  bus
);
  localparam int CW = ((WIDTH > STEPW) ? WIDTH : STEPW) + 1;

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             sticky_q, sticky_d;

  logic [CW-1:0]    step_ext, limit_ext, cnt_ext, s_ext, sum_ext;
  logic [CW-1:0]    up_wrap_ext, dn_wrap_ext;

  // Effective step is clamped to limit so a single step never crosses more than one boundary.
  always_comb begin
    step_ext    = CW'(bus.step);
    limit_ext   = CW'(bus.limit);
    cnt_ext     = CW'(cnt_q);
    s_ext       = (step_ext < limit_ext) ? step_ext : limit_ext;
    sum_ext     = cnt_ext + s_ext;
    up_wrap_ext = sum_ext - limit_ext - CW'(1);
    dn_wrap_ext = cnt_ext + limit_ext + CW'(1) - s_ext;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (!bus.load_n) begin
      cnt_d   = (bus.preld_val > bus.limit) ? bus.limit : bus.preld_val;
      state_d = RUN;
    end else if (state_q == RUN && bus.en && s_ext != '0) begin
      if (cnt_q > bus.limit) begin
        // Stale count after limit was lowered: snap back into range.
        ovf_d = bus.updown;
        unf_d = !bus.updown;
        cnt_d = bus.wrapstop ? '0 : bus.limit;
        if (!bus.wrapstop) state_d = HALT;
      end else if (bus.updown) begin
        if (sum_ext > limit_ext) begin
          ovf_d = 1'b1;
          if (bus.wrapstop) begin
            cnt_d = WIDTH'(up_wrap_ext);
          end else begin
            cnt_d   = bus.limit;
            state_d = HALT;
          end
        end else begin
          cnt_d = WIDTH'(sum_ext);
        end
      end else begin
        if (cnt_ext < s_ext) begin
          unf_d = 1'b1;
          if (bus.wrapstop) begin
            cnt_d = WIDTH'(dn_wrap_ext);
          end else begin
            cnt_d   = '0;
            state_d = HALT;
          end
        end else begin
          cnt_d = WIDTH'(cnt_ext - s_ext);
        end
      end
    end
    sticky_d = (ovf_d || unf_d) ? 1'b1 : (sticky_q && !bus.clr_flags);
  end

  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q  <= RUN;
      cnt_q    <= RESET_VAL;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.dcout      = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.tc         = bus.updown ? (cnt_q == bus.limit) : (cnt_q == '0);
endmodule

// File: tb/tb_counter_uni_mod.sv
// Directed plus randomized check of counter_uni_mod against an integer-arithmetic reference model.
module tb_counter_uni_mod;
  localparam int WIDTH = 8;
  localparam int STEPW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model state
  int   m_cnt;
  bit   m_halt;
  bit   m_ovf;
  bit   m_unf;
  bit   m_sticky;

  counter_uni_mod_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

  counter_uni_mod #(.WIDTH(WIDTH), .STEPW(STEPW), .RESET_VAL(8'd0)) dut (
    .clk_i      (clk),
    .areset_n_i (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_sticky = 0;
  endtask

  // Next-state of the counter from the inputs presented before the coming edge.
  task automatic model_step();
    int lim, s, md;
    lim = int'(bus.limit);
    s   = (int'(bus.step) < lim) ? int'(bus.step) : lim;
    md  = lim + 1;
    m_ovf = 0;
    m_unf = 0;
    if (!bus.load_n) begin
      m_cnt  = (int'(bus.preld_val) < lim) ? int'(bus.preld_val) : lim;
      m_halt = 0;
    end else if (!m_halt && bus.en && s != 0) begin
      if (m_cnt > lim) begin
        if (bus.updown) m_ovf = 1; else m_unf = 1;
        m_cnt  = bus.wrapstop ? 0 : lim;
        m_halt = !bus.wrapstop;
      end else if (bus.updown) begin
        if (m_cnt + s > lim) begin
          m_ovf = 1;
          if (bus.wrapstop) m_cnt = (m_cnt + s) % md;
          else begin m_cnt = lim; m_halt = 1; end
        end else m_cnt = m_cnt + s;
      end else begin
        if (m_cnt < s) begin
          m_unf = 1;
          if (bus.wrapstop) m_cnt = (m_cnt - s + md) % md;
          else begin m_cnt = 0; m_halt = 1; end
        end else m_cnt = m_cnt - s;
      end
    end
    if (m_ovf || m_unf) m_sticky = 1;
    else if (bus.clr_flags) m_sticky = 0;
  endtask

  task automatic check_all(input string tag);
    bit exp_tc;
    exp_tc = bus.updown ? (m_cnt == int'(bus.limit)) : (m_cnt == 0);
    chk({tag, ".dcout"},      32'(bus.dcout),      32'(m_cnt));
    chk({tag, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
    chk({tag, ".underflow"},  32'(bus.underflow),  32'(m_unf));
    chk({tag, ".ovf_sticky"}, 32'(bus.ovf_sticky), 32'(m_sticky));
    chk({tag, ".tc"},         32'(bus.tc),         32'(exp_tc));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] up_seq [5];
    checks = 0;
    errors = 0;
    up_seq[0] = 8'd3; up_seq[1] = 8'd6; up_seq[2] = 8'd9; up_seq[3] = 8'd2; up_seq[4] = 8'd5;

    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.load_n    = 1'b1;
    bus.preld_val = '0;
    bus.updown    = 1'b1;
    bus.wrapstop  = 1'b1;
    bus.limit     = 8'd255;
    bus.step      = 4'd1;
    bus.clr_flags = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Reset mid-count
    bus.load_n = 1'b0; bus.preld_val = 8'd37;
    cyc("load37");
    bus.load_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid");
    chk("reset_mid.dcout_const", 32'(bus.dcout), 32'd0);
    #1;
    rst_n = 1'b1;

    // Up wrap, limit 9 step 3
    bus.limit = 8'd9; bus.step = 4'd3; bus.wrapstop = 1'b1; bus.updown = 1'b1; bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("upwrap");
      chk("upwrap.seq", 32'(bus.dcout), 32'(up_seq[i]));
      chk("upwrap.ovf_const", 32'(bus.overflow), (i == 3) ? 32'd1 : 32'd0);
    end

    // Down stop into HALT, then load exits
    bus.en = 1'b0; bus.limit = 8'd200; bus.step = 4'd7; bus.wrapstop = 1'b0; bus.updown = 1'b0;
    bus.load_n = 1'b0; bus.preld_val = 8'd10;
    cyc("dn_load");
    bus.load_n = 1'b1; bus.en = 1'b1;
    cyc("dn_3");
    chk("dn.first_const", 32'(bus.dcout), 32'd3);
    cyc("dn_0");
    chk("dn.unf_const", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 5; i++) cyc("dn_halt");
    chk("dn.halt_const", 32'(bus.dcout), 32'd0);
    bus.load_n = 1'b0; bus.preld_val = 8'd250;
    cyc("dn_reload");
    chk("dn.reload_const", 32'(bus.dcout), 32'd200);
    bus.load_n = 1'b1;
    cyc("dn_run");
    chk("dn.run_const", 32'(bus.dcout), 32'd193);

    // Load priority over en, with clamp
    bus.load_n = 1'b0; bus.en = 1'b1; bus.preld_val = 8'd50; bus.limit = 8'd40;
    cyc("ld_clamp");
    chk("ld_clamp.const", 32'(bus.dcout), 32'd40);
    bus.load_n = 1'b1;

    // Limit lowered below count: wrap then stop
    bus.en = 1'b0; bus.limit = 8'd255; bus.load_n = 1'b0; bus.preld_val = 8'd100;
    cyc("lo_load");
    bus.load_n = 1'b1; bus.limit = 8'd20; bus.updown = 1'b1; bus.wrapstop = 1'b1; bus.step = 4'd1; bus.en = 1'b1;
    cyc("lo_wrap");
    chk("lo_wrap.const", 32'(bus.dcout), 32'd0);
    bus.en = 1'b0; bus.limit = 8'd255; bus.load_n = 1'b0;
    cyc("lo_load2");
    bus.load_n = 1'b1; bus.limit = 8'd20; bus.wrapstop = 1'b0; bus.en = 1'b1;
    cyc("lo_stop");
    chk("lo_stop.const", 32'(bus.dcout), 32'd20);
    cyc("lo_halt1");
    bus.wrapstop = 1'b1;
    cyc("lo_halt2");
    chk("lo_halt.ovf_const", 32'(bus.overflow), 32'd0);

    // Sticky flag set/clear race
    bus.en = 1'b0; bus.limit = 8'd9; bus.load_n = 1'b0; bus.preld_val = 8'd9; bus.clr_flags = 1'b1;
    cyc("flg_clr");
    chk("flg_clr.const", 32'(bus.ovf_sticky), 32'd0);
    bus.load_n = 1'b1; bus.en = 1'b1; bus.step = 4'd3; bus.updown = 1'b1; bus.wrapstop = 1'b1;
    cyc("flg_race");
    chk("flg_race.const", 32'(bus.ovf_sticky), 32'd1);
    bus.en = 1'b0;
    cyc("flg_quiet");
    chk("flg_quiet.const", 32'(bus.ovf_sticky), 32'd0);
    bus.clr_flags = 1'b0;

    // limit = 0 holds at zero
    bus.limit = 8'd0; bus.load_n = 1'b0; bus.preld_val = 8'd0;
    cyc("lim0_load");
    bus.load_n = 1'b1; bus.en = 1'b1; bus.step = 4'd5;
    for (int i = 0; i < 3; i++) cyc("lim0");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.en        = 1'($urandom_range(0, 3) != 0);
      bus.load_n    = 1'($urandom_range(0, 9) != 0);
      bus.preld_val = WIDTH'($urandom);
      bus.updown    = 1'($urandom);
      bus.wrapstop  = 1'($urandom_range(0, 3) != 0);
      bus.step      = STEPW'($urandom);
      bus.clr_flags = 1'($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.limit = WIDTH'($urandom_range(0, 60));
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_uni_mod.md
Name: counter_uni_mod

Overview:
- Parametrised successor to the 8-bit up/down preload counter.
- Adds generic width, a programmable modulus (run-time `limit`), a programmable step size and a count enable.
- Adds separate overflow and underflow pulses, a sticky overflow flag, and a HALT state for stop mode.
- Used as the general-purpose timebase/event counter in the datapath. Single clock domain.

Parameters:
- WIDTH, 8: counter, `limit` and `preld_val` width.
- STEPW, 4: width of the `step` input.
- RESET_VAL, 0: value loaded into `dcout` on reset. Must be ≤ `limit` in use.

Ports:
- clk  in  1  : single clock; all state changes on rising edge.
- _areset  in  1  : asynchronous, active-low reset.
- en  in  1  : count enable, active-high.
- _load  in  1  : synchronous load of `preld_val`, active-low.
- preld_val  in  WIDTH  : preload value.
- _updown  in  1  : 1 = count up, 0 = count down.
- _wrapstop  in  1  : 1 = wrap modulo (`limit`+1), 0 = stop at boundary.
- limit  in  WIDTH  : top count value; range is 0..`limit`.
- step  in  STEPW  : increment/decrement amount per enabled cycle.
- clr_flags  in  1  : synchronous clear of `ovf_sticky`.
- dcout  out  WIDTH  : registered count.
- overflow  out  1  : registered one-cycle pulse on an up-boundary crossing.
- underflow  out  1  : registered one-cycle pulse on a down-boundary crossing.
- tc  out  1  : combinational terminal count. High when (`_updown`=1 and `dcout`==`limit`) or (`_updown`=0 and `dcout`==0).
- ovf_sticky  out  1  : set by any `overflow` or `underflow` pulse; held until `clr_flags` or reset.

Behaviour:
- **Reset** (`_areset`=0, asynchronous):
  - `dcout`=RESET_VAL; `overflow`=`underflow`=`ovf_sticky`=0; state=RUN.
  - Deassertion takes effect at the next rising edge.
- **Priority per edge:** reset > `_load` > counting (`en`) > hold.
- **Effective step:** s = min(`step`, `limit`). s=0 means hold, with no pulses.
- **Load** (`_load`=0):
  - `dcout` = min(`preld_val`, `limit`); state → RUN.
  - No pulses. Load overrides `en` and also exits HALT.
- **FSM states:**
  - RUN: counts when `en`=1.
  - HALT: `dcout` frozen and `en` ignored; exits only via `_load`=0 or reset.
- **Up count** (RUN, `en`=1, `_updown`=1). Compute n = `dcout` + s in WIDTH+1 bits.
  - n ≤ `limit`: `dcout` ← n.
  - n > `limit`, wrap: `dcout` ← n − `limit` − 1; `overflow`=1 for one cycle.
  - n > `limit`, stop: `dcout` ← `limit`; `overflow`=1; state → HALT.
- **Down count** (RUN, `en`=1, `_updown`=0).
  - `dcout` ≥ s: `dcout` ← `dcout` − s.
  - `dcout` < s, wrap: `dcout` ← `dcout` + `limit` + 1 − s; `underflow`=1.
  - `dcout` < s, stop: `dcout` ← 0; `underflow`=1; state → HALT.
- **Out-of-range count** (`dcout` > `limit` after `limit` is lowered):
  - The next enabled count in either direction forces `dcout` to 0 (wrap) or `limit` (stop).
  - Pulse `overflow` if counting up, `underflow` if counting down. Stop mode also → HALT.
- **Pulse timing:** `overflow`/`underflow` are registered and coincide with the cycle in which the new `dcout` is visible. They are 0 on every other cycle, including load and hold cycles.
- **ovf_sticky:**
  - Set on the same edge that raises either pulse.
  - `clr_flags`=1 clears it unless a pulse is set on that same edge; set wins.
- **Mode changes:**
  - `_updown` and `_wrapstop` are sampled every edge, so a change takes effect immediately.
  - Changing `_wrapstop` does not exit HALT.
- **limit=0:** `dcout` stays 0. An enabled count with `step`≠0 has s=0, so it holds with no pulses.
- **Latency:** one cycle from input sample to `dcout`/pulse update; `tc` follows `dcout` combinationally.

Test Plan:
- Reset mid-count: WIDTH=8, RESET_VAL=0, `dcout`=37, pull `_areset` low between edges -> `dcout`=0 and all flags 0 immediately, before the next edge.
- Up wrap: `limit`=9, `step`=3, wrap, start 0, `en`=1 -> `dcout` sequence 3,6,9,2,5. `overflow` high only in the cycle showing 2. `ovf_sticky`=1 thereafter.
- Down stop/HALT: `limit`=200, `step`=7, stop, load 10, count down -> `dcout` 3, then 0 with `underflow` pulse; `dcout` stays 0 with `en`=1 for ≥5 cycles. `_load`=0 with `preld_val`=250 -> `dcout`=200, state RUN.
- Load priority and clamp: `_load`=0 and `en`=1 on the same edge, `preld_val`=50, `limit`=40 -> `dcout`=40, no pulse.
- Limit lowered: `dcout`=100, set `limit`=20, up, wrap -> next `dcout`=0 with `overflow`. Repeat with stop -> `dcout`=20, HALT.
- Flag race: `clr_flags`=1 on the same edge as an `overflow` pulse -> `ovf_sticky`=1. `clr_flags`=1 on a quiet cycle -> `ovf_sticky`=0.
